// File: rtl/id_ex.sv
// ID/EX pipeline register: 2-entry elastic buffer (main + skid) between decode and execute.
// The ready output is registered, so execute-side backpressure never reaches decode combinationally.
module id_ex (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_wen_i,
    input  logic        id_valid_i,
    output logic        id_ready_o,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_wen_o,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [1:0]  occ_o
);
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    localparam bundle_t NOP_B = '{32'h0000_0013, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0};

    state_t  r_state, w_state_nxt;
    bundle_t r_main, w_main_nxt;
    bundle_t r_skid, w_skid_nxt;
    bundle_t w_in;
    logic    r_ready, w_ready_nxt;
    logic    w_accept, w_deliver;

    assign w_in      = '{inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};
    assign w_accept  = id_valid_i && r_ready;
    assign w_deliver = (r_state != EMPTY) && ex_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_main  <= NOP_B;
            r_skid  <= NOP_B;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Main is reloaded with NOP whenever it goes invalid so the outputs need no mux.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush_i) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = NOP_B;
            w_skid_nxt  = NOP_B;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = w_in;
                    end
                end
                ONE: begin
                    if (w_accept && w_deliver) begin
                        w_main_nxt = w_in;
                    end else if (w_accept) begin
                        w_state_nxt = FULL;
                        w_skid_nxt  = w_in;
                    end else if (w_deliver) begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = NOP_B;
                    end
                end
                FULL: begin
                    if (w_deliver) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = NOP_B;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = NOP_B;
                    w_skid_nxt  = NOP_B;
                end
            endcase
        end
    end

    assign w_ready_nxt = (w_state_nxt != FULL);

    assign id_ready_o  = r_ready;
    assign ex_valid_o  = (r_state != EMPTY);
    assign occ_o       = r_state;
    assign inst_o      = r_main.inst;
    assign inst_addr_o = r_main.addr;
    assign op1_o       = r_main.op1;
    assign op2_o       = r_main.op2;
    assign rd_addr_o   = r_main.rd;
    assign reg_wen_o   = r_main.wen;
endmodule

// File: tb/tb_id_ex.sv
// Bench for id_ex: directed scenarios plus random traffic, with a negedge scoreboard
// monitor that tracks accepted bundles in a queue and checks delivery order and stall stability.
module tb_id_ex;
    logic        clk, rst_n;
    logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wen_i, id_valid_i, id_ready_o, flush_i;
    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen_o, ex_valid_o, ex_ready_i;
    logic [1:0]  occ_o;

    localparam logic [133:0] NOP_V = {32'h0000_0013, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0};

    int n_chk = 0;
    int n_pass = 0;
    logic [133:0] sb[$];
    logic         stall_prev = 1'b0;
    logic [133:0] prev_out;

    id_ex dut (
        .clk(clk), .rst_n(rst_n),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .flush_i(flush_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .occ_o(occ_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [133:0] out_v();
        return {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o};
    endfunction

    // Scoreboard monitor: inputs change just after posedge, so negedge sees what the next edge does.
    always @(negedge clk) begin
        logic [133:0] cur, exp_b;
        logic [3:0]   exp_s;
        if (!rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            cur   = out_v();
            exp_s = {sb.size() != 0, sb.size() < 2, 2'(sb.size())};
            n_chk++;
            if ({ex_valid_o, id_ready_o, occ_o} !== exp_s)
                $display("FAIL state: valid/ready/occ got %b expected %b", {ex_valid_o, id_ready_o, occ_o}, exp_s);
            else n_pass++;
            if (!ex_valid_o) begin
                n_chk++;
                if (cur !== NOP_V) $display("FAIL nop_idle: got %h expected %h", cur, NOP_V);
                else n_pass++;
            end
            if (stall_prev) begin
                n_chk++;
                if (cur !== prev_out) $display("FAIL stall_stable: got %h expected %h", cur, prev_out);
                else n_pass++;
            end
            if (flush_i) sb.delete();
            else begin
                if (ex_valid_o && ex_ready_i) begin
                    n_chk++;
                    if (sb.size() == 0) $display("FAIL deliver: got %h expected no delivery", cur);
                    else begin
                        exp_b = sb.pop_front();
                        if (cur !== exp_b) $display("FAIL deliver: got %h expected %h", cur, exp_b);
                        else n_pass++;
                    end
                end
                if (id_valid_i && id_ready_o)
                    sb.push_back({inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i});
            end
            stall_prev = ex_valid_o && !ex_ready_i && !flush_i;
            prev_out   = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [133:0] b);
        id_valid_i = v;
        {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i} = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0);
        ex_ready_i = 1'b0;
        flush_i = 1'b0;
        #12;
        n_chk++;
        if ({inst_o, reg_wen_o, ex_valid_o, id_ready_o, occ_o} !== {32'h13, 1'b0, 1'b0, 1'b1, 2'd0})
            $display("FAIL reset_in: got %h/%b/%b/%b/%0d expected 13/0/0/1/0", inst_o, reg_wen_o, ex_valid_o, id_ready_o, occ_o);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        tick();
        n_chk++;
        if ({inst_o, reg_wen_o, ex_valid_o, id_ready_o, occ_o} !== {32'h13, 1'b0, 1'b0, 1'b1, 2'd0})
            $display("FAIL reset_out: got %h/%b/%b/%b/%0d expected 13/0/0/1/0", inst_o, reg_wen_o, ex_valid_o, id_ready_o, occ_o);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [133:0] a, b;
        a = {32'h0050_0093, 32'h0, 32'h0, 32'h5, 5'd1, 1'b1};
        b = {32'h0020_81b3, 32'h4, 32'h5, 32'h7, 5'd3, 1'b1};
        ex_ready_i = 1'b1;
        drive(1'b1, a);
        tick();
        n_chk++;
        if ({out_v(), occ_o} !== {a, 2'd1}) $display("FAIL stream_a: got %h occ %0d expected %h occ 1", out_v(), occ_o, a);
        else n_pass++;
        drive(1'b1, b);
        tick();
        n_chk++;
        if ({out_v(), occ_o} !== {b, 2'd1}) $display("FAIL stream_b: got %h occ %0d expected %h occ 1", out_v(), occ_o, b);
        else n_pass++;
        drive(1'b0, '0);
        tick();
        n_chk++;
        if (occ_o !== 2'd0) $display("FAIL stream_drain: got occ %0d expected 0", occ_o);
        else n_pass++;
    endtask

    task automatic fill_full(input logic [133:0] a, input logic [133:0] b);
        ex_ready_i = 1'b0;
        drive(1'b1, a);
        tick();
        drive(1'b1, b);
        tick();
        drive(1'b0, '0);
    endtask

    task automatic test_backpressure();
        logic [133:0] a, b;
        a = {32'h0010_0113, 32'h10, 32'h1, 32'h1, 5'd2, 1'b1};
        b = {32'h0000_0063, 32'h14, 32'hdead_beef, 32'h1234_5678, 5'd0, 1'b0};
        fill_full(a, b);
        tick();
        n_chk++;
        if ({out_v(), occ_o, id_ready_o} !== {a, 2'd2, 1'b0})
            $display("FAIL bp_full: got %h occ %0d rdy %b expected %h occ 2 rdy 0", out_v(), occ_o, id_ready_o, a);
        else n_pass++;
        ex_ready_i = 1'b1;
        tick();
        n_chk++;
        if ({out_v(), occ_o, id_ready_o} !== {b, 2'd1, 1'b1})
            $display("FAIL bp_first: got %h occ %0d rdy %b expected %h occ 1 rdy 1", out_v(), occ_o, id_ready_o, b);
        else n_pass++;
        tick();
        n_chk++;
        if ({ex_valid_o, occ_o} !== {1'b0, 2'd0}) $display("FAIL bp_drain: got valid %b occ %0d expected 0 0", ex_valid_o, occ_o);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [133:0] c;
        c = {32'h00c0_0513, 32'h40, 32'hc, 32'hc, 5'd10, 1'b1};
        fill_full({32'h1, 32'h20, 32'h2, 32'h3, 5'd4, 1'b1}, {32'h5, 32'h24, 32'h6, 32'h7, 5'd8, 1'b1});
        drive(1'b1, c);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, '0);
        n_chk++;
        if ({out_v(), ex_valid_o, occ_o} !== {NOP_V, 1'b0, 2'd0})
            $display("FAIL flush: got %h valid %b occ %0d expected %h 0 0", out_v(), ex_valid_o, occ_o, NOP_V);
        else n_pass++;
        ex_ready_i = 1'b1;
        repeat (3) tick();
        n_chk++;
        if (ex_valid_o !== 1'b0) $display("FAIL flush_drop: got valid %b expected 0", ex_valid_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [133:0] d;
        d = {32'h0dd0_0d13, 32'h80, 32'hd, 32'hd, 5'd13, 1'b1};
        fill_full({32'h11, 32'h30, 32'h1, 32'h1, 5'd1, 1'b1}, {32'h22, 32'h34, 32'h2, 32'h2, 5'd2, 1'b0});
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({out_v(), ex_valid_o, occ_o, id_ready_o} !== {NOP_V, 1'b0, 2'd0, 1'b1})
            $display("FAIL reset_mid: got %h valid %b occ %0d rdy %b expected %h 0 0 1", out_v(), ex_valid_o, occ_o, id_ready_o, NOP_V);
        else n_pass++;
        sb.delete();
        stall_prev = 1'b0;
        #1 rst_n = 1'b1;
        ex_ready_i = 1'b1;
        tick();
        drive(1'b1, d);
        tick();
        drive(1'b0, '0);
        n_chk++;
        if ({out_v(), ex_valid_o} !== {d, 1'b1}) $display("FAIL reset_first: got %h expected %h", out_v(), d);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 99) < 60, {$urandom(), $urandom(), $urandom(), $urandom(), 5'($urandom()), 1'($urandom())});
            ex_ready_i = $urandom_range(0, 99) < 55;
            flush_i    = $urandom_range(0, 99) < 2;
            tick();
        end
        drive(1'b0, '0);
        flush_i = 1'b0;
        ex_ready_i = 1'b1;
        repeat (4) tick();
        n_chk++;
        if ({ex_valid_o, occ_o} !== {1'b0, 2'd0}) $display("FAIL rand_drain: got valid %b occ %0d expected 0 0", ex_valid_o, occ_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
